// File: rtl/match_window_counter_pkg.sv
// Shared definitions for the match window counter: FSM encoding and
// window-counter sizing.
package match_window_counter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // Width of a counter that must reach window-1; never narrower than 1 bit.
   function automatic int win_width(input int window);
      if (window <= 2) begin
         return 1;
      end else begin
         return $clog2(window);
      end
   endfunction

endpackage

// File: rtl/match_window_counter_rise_edge_det.sv
// Registered rising-edge detector: rise is high in the cycle where d is high
// and was low on the previous clock edge.
module match_window_counter_rise_edge_det
   import match_window_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Previous-cycle copy of d, tracked every cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/match_window_counter.sv
// Counts detector rising edges over fixed windows of WINDOW cycles and posts
// each window's count over a valid/ready handshake, flagging dropped results.
module match_window_counter
   import match_window_counter_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             det,
   output logic [CNT_W-1:0] cnt_data,
   output logic             cnt_sat,
   output logic             cnt_valid,
   input  logic             cnt_ready,
   output logic             overrun,
   input  logic             clr_ovr
);

   localparam int               WIN_W    = win_width(WINDOW);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

   state_t           state;
   state_t           state_next;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_cnt_next;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_next;
   logic             sat;
   logic             sat_next;
   logic             ev;
   logic             inc_sat;
   logic [CNT_W-1:0] fin_acc;
   logic             fin_sat;
   logic             win_end;
   logic             drop;
   logic             load;

   match_window_counter_rise_edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (det),
      .rise (ev)
   );

   // Window sequencing and event accumulation; fin_* already include this cycle's event.
   always_comb begin
      state_next   = state;
      win_cnt_next = win_cnt;
      acc_next     = acc;
      sat_next     = sat;
      win_end      = 1'b0;
      inc_sat      = ev & (acc == ACC_MAX);
      fin_acc      = (ev && !inc_sat) ? acc + CNT_W'(1) : acc;
      fin_sat      = sat | inc_sat;
      case (state)
         IDLE: begin
            win_cnt_next = '0;
            acc_next     = '0;
            sat_next     = 1'b0;
            if (en) begin
               state_next = COUNT;
            end else begin
               state_next = IDLE;
            end
         end
         COUNT: begin
            if (!en) begin
               state_next   = IDLE;
               win_cnt_next = '0;
               acc_next     = '0;
               sat_next     = 1'b0;
            end else if (win_cnt == WIN_LAST) begin
               win_end      = 1'b1;
               win_cnt_next = '0;
               acc_next     = '0;
               sat_next     = 1'b0;
            end else begin
               win_cnt_next = win_cnt + WIN_W'(1);
               acc_next     = fin_acc;
               sat_next     = fin_sat;
            end
         end
         default: begin
            state_next   = IDLE;
            win_cnt_next = '0;
            acc_next     = '0;
            sat_next     = 1'b0;
         end
      endcase
   end

   // A finished window is dropped only when an unconsumed result is not being taken.
   always_comb begin
      drop = win_end & cnt_valid & ~cnt_ready;
      load = win_end & ~drop;
   end

   // FSM and window counter state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         win_cnt <= '0;
         acc     <= '0;
         sat     <= 1'b0;
      end else begin
         state   <= state_next;
         win_cnt <= win_cnt_next;
         acc     <= acc_next;
         sat     <= sat_next;
      end
   end

   // Result register, handshake and sticky overrun (set wins over clear).
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_data  <= '0;
         cnt_sat   <= 1'b0;
         cnt_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            cnt_data  <= fin_acc;
            cnt_sat   <= fin_sat;
            cnt_valid <= 1'b1;
         end else if (cnt_valid && cnt_ready) begin
            cnt_valid <= 1'b0;
         end else begin
            cnt_valid <= cnt_valid;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_ovr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
      end
   end

endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench: two instances (CNT_W=4 and CNT_W=2) share stimulus and
// are compared every cycle against an unbounded-count window model.
module tb_match_window_counter;

   localparam int WINDOW = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       det = 1'b0;
   logic       cnt_ready = 1'b0;
   logic       clr_ovr = 1'b0;

   logic [3:0] d4;
   logic       s4, v4, o4;
   logic [1:0] d2;
   logic       s2, v2, o2;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit m_prev_det = 1'b0;
   bit m_active   = 1'b0;
   int m_pos      = 0;
   int m_n        = 0;
   int m_res      = 0;
   bit m_valid    = 1'b0;
   bit m_ovr      = 1'b0;

   typedef struct {
      logic [15:0] pat;
      int          exp4;
      bit          sat4;
      int          exp2;
      bit          sat2;
   } row_t;

   row_t tbl [10];

   match_window_counter #(.WINDOW(WINDOW), .CNT_W(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .det(det),
      .cnt_data(d4), .cnt_sat(s4), .cnt_valid(v4), .cnt_ready(cnt_ready),
      .overrun(o4), .clr_ovr(clr_ovr)
   );

   match_window_counter #(.WINDOW(WINDOW), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .det(det),
      .cnt_data(d2), .cnt_sat(s2), .cnt_valid(v2), .cnt_ready(cnt_ready),
      .overrun(o2), .clr_ovr(clr_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Window result as seen through a CNT_W-bit saturating counter.
   function automatic int sat_val(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic model_step();
      bit ev;
      bit end_now;
      int res;
      ev      = det && !m_prev_det;
      end_now = 1'b0;
      res     = 0;
      if (!rst) begin
         m_prev_det = 1'b0; m_active = 1'b0; m_pos = 0; m_n = 0;
         m_res = 0; m_valid = 1'b0; m_ovr = 1'b0;
      end else begin
         if (!m_active) begin
            if (en) begin
               m_active = 1'b1; m_pos = 0; m_n = 0;
            end
         end else if (!en) begin
            m_active = 1'b0;
         end else begin
            m_n += ev ? 1 : 0;
            if (m_pos == WINDOW - 1) begin
               end_now = 1'b1; res = m_n; m_pos = 0; m_n = 0;
            end else begin
               m_pos++;
            end
         end
         if (end_now && m_valid && !cnt_ready) m_ovr = 1'b1;
         else if (clr_ovr) m_ovr = 1'b0;
         if (end_now && (!m_valid || cnt_ready)) begin
            m_res = res; m_valid = 1'b1;
         end else if (!end_now && m_valid && cnt_ready) begin
            m_valid = 1'b0;
         end
         m_prev_det = det;
      end
   endtask

   task automatic compare_model();
      chk("mdl_valid4",   v4, m_valid);
      chk("mdl_overrun4", o4, m_ovr);
      chk("mdl_data4",    d4, sat_val(m_res, 15));
      chk("mdl_sat4",     s4, m_res > 15);
      chk("mdl_valid2",   v2, m_valid);
      chk("mdl_overrun2", o2, m_ovr);
      chk("mdl_data2",    d2, sat_val(m_res, 3));
      chk("mdl_sat2",     s2, m_res > 3);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; det = 1'b0; cnt_ready = 1'b0; clr_ovr = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // IDLE -> COUNT transition cycle; the next tick is window cycle 0.
   task automatic start();
      en = 1'b1; det = 1'b0;
      tick();
   endtask

   task automatic run_window(input logic [15:0] pat, input logic [15:0] rdy);
      for (int c = 0; c < WINDOW; c++) begin
         en = 1'b1; det = pat[c]; cnt_ready = rdy[c];
         tick();
      end
   endtask

   initial begin
      tbl[0] = '{16'h8224, 4, 1'b0, 3, 1'b1};
      tbl[1] = '{16'h1FF8, 1, 1'b0, 1, 1'b0};
      tbl[2] = '{16'h5555, 8, 1'b0, 3, 1'b1};
      tbl[3] = '{16'h0555, 6, 1'b0, 3, 1'b1};
      tbl[4] = '{16'h0080, 1, 1'b0, 1, 1'b0};
      tbl[5] = '{16'h0000, 0, 1'b0, 0, 1'b0};
      tbl[6] = '{16'hFFFF, 1, 1'b0, 1, 1'b0};
      tbl[7] = '{16'h0001, 0, 1'b0, 0, 1'b0};
      tbl[8] = '{16'hAAAA, 8, 1'b0, 3, 1'b1};
      tbl[9] = '{16'h8001, 1, 1'b0, 1, 1'b0};

      // reset state
      do_reset();
      do_reset();
      chk("rst_valid", v4, 0);
      chk("rst_data", d4, 0);
      chk("rst_overrun", o4, 0);

      // back-to-back table windows, consumer always ready
      start();
      for (int i = 0; i < 10; i++) begin
         run_window(tbl[i].pat, 16'hFFFF);
         chk("tbl_valid", v4, 1);
         chk("tbl_data4", d4, tbl[i].exp4);
         chk("tbl_sat4",  s4, tbl[i].sat4);
         chk("tbl_data2", d2, tbl[i].exp2);
         chk("tbl_sat2",  s2, tbl[i].sat2);
      end

      // reset mid-window
      for (int c = 0; c < 10; c++) begin
         en = 1'b1; cnt_ready = 1'b1; det = (c == 1 || c == 3 || c == 5);
         tick();
      end
      rst = 1'b0; det = 1'b1;
      tick();
      chk("midrst_valid", v4, 0);
      chk("midrst_data", d4, 0);
      chk("midrst_sat", s4, 0);
      chk("midrst_overrun", o4, 0);
      rst = 1'b1;
      start();
      run_window(16'h0104, 16'hFFFF);
      chk("midrst_next_valid", v4, 1);
      chk("midrst_next_data", d4, 2);

      // stall across two window ends, then clear and consume
      do_reset();
      start();
      run_window(16'h0024, 16'h0000);
      chk("stall_valid1", v4, 1);
      chk("stall_data1", d4, 2);
      chk("stall_ovr1", o4, 0);
      run_window(16'h0124, 16'h0000);
      chk("stall_valid2", v4, 1);
      chk("stall_data2", d4, 2);
      chk("stall_ovr2", o4, 1);
      en = 1'b0; det = 1'b0; cnt_ready = 1'b0; clr_ovr = 1'b1;
      tick();
      chk("clr_ovr", o4, 0);
      chk("clr_valid", v4, 1);
      clr_ovr = 1'b0; cnt_ready = 1'b1;
      tick();
      chk("consume_valid", v4, 0);
      chk("consume_data", d4, 2);

      // back-to-back load on the window-end cycle
      do_reset();
      start();
      run_window(16'h0024, 16'h0000);
      run_window(16'h0124, 16'h8000);
      chk("b2b_valid", v4, 1);
      chk("b2b_data", d4, 3);
      chk("b2b_ovr", o4, 0);

      // enable drop at window cycle 7, then a fresh window
      for (int c = 0; c < 7; c++) begin
         en = 1'b1; cnt_ready = 1'b1; det = (c == 2);
         tick();
      end
      en = 1'b0; det = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      chk("endrop_valid", v4, 0);
      chk("endrop_data", d4, 3);
      start();
      run_window(16'h8010, 16'hFFFF);
      chk("reen_valid", v4, 1);
      chk("reen_data", d4, 2);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 499) != 0);
         en        = ($urandom_range(0, 31) != 0);
         det       = ($urandom_range(0, 2) == 0);
         cnt_ready = ($urandom_range(0, 3) != 0);
         clr_ovr   = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
